// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// register-select width and the default memory-wait timeout.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LU   = 2'd1,
        MEMW = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam int          REG_SEL_W       = 3;
    localparam int unsigned MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: flags a decode-stage read of a register that a load in
// execute has not yet produced. Purely combinational.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_SEL_W-1:0] rs_sel,
    input  logic [REG_SEL_W-1:0] rt_sel,
    input  logic                 rs_used,
    input  logic                 rt_used,
    input  logic                 mem_en,
    input  logic                 mem_wr,
    input  logic                 reg_en,
    input  logic [REG_SEL_W-1:0] writeregsel,
    output logic                 lu
);

    logic load;

    always_comb begin
        load = mem_en & ~mem_wr & reg_en;
        lu   = load & ((rs_used & (rs_sel == writeregsel)) |
                       (rt_used & (rt_sel == writeregsel)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Optional stall-cycle
// counter is built only when PIPE_STALL_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_SEL_W-1:0] ID_rs_sel,
    input  logic [REG_SEL_W-1:0] ID_rt_sel,
    input  logic                 ID_rs_used,
    input  logic                 ID_rt_used,
    input  logic                 IE_mem_en,
    input  logic                 IE_mem_wr,
    input  logic                 IE_reg_en,
    input  logic [REG_SEL_W-1:0] IE_writeregsel,
    input  logic                 IE_branch_taken,
    input  logic                 IM_mem_en,
    input  logic                 mem_done,
    input  logic                 IM_HALT,
    output logic                 PC_en,
    output logic                 IF_ID_en,
    output logic                 ID_IE_en,
    output logic                 IE_IM_en,
    output logic                 IM_IW_en,
    output logic                 IF_ID_flush,
    output logic                 ID_IE_bubble,
    output logic                 IM_IW_bubble,
    output logic                 halted,
    output logic                 err,
    output logic [1:0]           state,
    output logic [15:0]          stall_cycles
);

    state_t            state_q, cur, next_state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              lu_raw, lu, miss, br, halt_ev, load_cnt;

    hazard_detect u_hazard_detect (
        .rs_sel      (ID_rs_sel),
        .rt_sel      (ID_rt_sel),
        .rs_used     (ID_rs_used),
        .rt_used     (ID_rt_used),
        .mem_en      (IE_mem_en),
        .mem_wr      (IE_mem_wr),
        .reg_en      (IE_reg_en),
        .writeregsel (IE_writeregsel),
        .lu          (lu_raw)
    );

    // While rst is high the decode behaves as RUN with every input at zero.
    assign cur     = rst ? RUN : state_q;
    assign lu      = ~rst & lu_raw;
    assign miss    = ~rst & IM_mem_en & ~mem_done;
    assign br      = ~rst & IE_branch_taken;
    assign halt_ev = ~rst & IM_HALT;
    assign state   = state_q;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        PC_en        = 1'b1;
        IF_ID_en     = 1'b1;
        ID_IE_en     = 1'b1;
        IE_IM_en     = 1'b1;
        IM_IW_en     = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_IE_bubble = 1'b0;
        IM_IW_bubble = 1'b0;
        halted       = 1'b0;
        load_cnt     = 1'b0;
        next_state   = RUN;
        unique case (cur)
            RUN, LU: begin
                if (halt_ev) begin
                    {PC_en, IF_ID_en, ID_IE_en, IE_IM_en} = 4'b0000;
                    next_state = HALT;
                end else if (miss) begin
                    {PC_en, IF_ID_en, ID_IE_en, IE_IM_en} = 4'b0000;
                    IM_IW_bubble = 1'b1;
                    load_cnt     = 1'b1;
                    next_state   = MEMW;
                end else if (cur == RUN && br) begin
                    // A taken branch squashes the dependent instruction, so it beats lu.
                    IF_ID_flush  = 1'b1;
                    ID_IE_bubble = 1'b1;
                end else if (cur == RUN && lu) begin
                    PC_en        = 1'b0;
                    IF_ID_en     = 1'b0;
                    ID_IE_bubble = 1'b1;
                    next_state   = LU;
                end
            end
            MEMW: begin
                if (!mem_done) begin
                    {PC_en, IF_ID_en, ID_IE_en, IE_IM_en} = 4'b0000;
                    IM_IW_bubble = 1'b1;
                    next_state   = MEMW;
                end
            end
            HALT: begin
                {PC_en, IF_ID_en, ID_IE_en, IE_IM_en, IM_IW_en} = 5'b00000;
                halted     = 1'b1;
                next_state = HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            err      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state_q <= next_state;
            if (load_cnt) begin
                wait_cnt <= CNT_W'(1);
            end else if (state_q == MEMW && !mem_done) begin
                // Counter holds at the limit; err stays set until reset.
                if (wait_cnt >= CNT_W'(MEM_TIMEOUT)) begin
                    err <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!PC_en && state_q != HALT && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl; honours PIPE_STALL_CNT_EN
// when predicting stall_cycles.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ID_rs_sel, ID_rt_sel, IE_writeregsel;
    logic       ID_rs_used, ID_rt_used, IE_mem_en, IE_mem_wr, IE_reg_en;
    logic       IE_branch_taken, IM_mem_en, mem_done, IM_HALT;
    logic       PC_en, IF_ID_en, ID_IE_en, IE_IM_en, IM_IW_en;
    logic       IF_ID_flush, ID_IE_bubble, IM_IW_bubble, halted, err;
    logic [1:0] state;
    logic [15:0] stall_cycles;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .ID_rs_sel(ID_rs_sel), .ID_rt_sel(ID_rt_sel),
        .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
        .IE_mem_en(IE_mem_en), .IE_mem_wr(IE_mem_wr), .IE_reg_en(IE_reg_en),
        .IE_writeregsel(IE_writeregsel), .IE_branch_taken(IE_branch_taken),
        .IM_mem_en(IM_mem_en), .mem_done(mem_done), .IM_HALT(IM_HALT),
        .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_IE_en(ID_IE_en),
        .IE_IM_en(IE_IM_en), .IM_IW_en(IM_IW_en),
        .IF_ID_flush(IF_ID_flush), .ID_IE_bubble(ID_IE_bubble),
        .IM_IW_bubble(IM_IW_bubble), .halted(halted), .err(err),
        .state(state), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ctl;
        logic        hl;
        logic        er;
        logic [1:0]  st;
        logic [15:0] stall;
    } exp_t;

    // ctl = {PC_en, IF_ID_en, ID_IE_en, IE_IM_en, IM_IW_en, IF_ID_flush, ID_IE_bubble, IM_IW_bubble}
    localparam logic [7:0] C_RUN  = 8'b11111_000;
    localparam logic [7:0] C_LU   = 8'b00111_010;
    localparam logic [7:0] C_MISS = 8'b00001_001;
    localparam logic [7:0] C_BR   = 8'b11111_110;
    localparam logic [7:0] C_HENT = 8'b00001_000;
    localparam logic [7:0] C_HALT = 8'b00000_000;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [15:0] exp_stall = 16'h0000;
    logic [7:0]  ctl_obs;

    assign ctl_obs = {PC_en, IF_ID_en, ID_IE_en, IE_IM_en, IM_IW_en,
                      IF_ID_flush, ID_IE_bubble, IM_IW_bubble};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        ID_rs_sel = 3'd0; ID_rt_sel = 3'd0; IE_writeregsel = 3'd0;
        ID_rs_used = 1'b0; ID_rt_used = 1'b0;
        IE_mem_en = 1'b0; IE_mem_wr = 1'b0; IE_reg_en = 1'b0;
        IE_branch_taken = 1'b0; IM_mem_en = 1'b0; mem_done = 1'b0; IM_HALT = 1'b0;
    endtask

    // Load r3 in execute; decode reads r3 through rs or rt.
    task automatic set_load_use(input logic via_rt);
        IE_mem_en = 1'b1; IE_mem_wr = 1'b0; IE_reg_en = 1'b1; IE_writeregsel = 3'd3;
        ID_rt_sel = via_rt ? 3'd3 : 3'd5; ID_rt_used = 1'b1;
        ID_rs_sel = via_rt ? 3'd6 : 3'd3; ID_rs_used = 1'b1;
    endtask

    // Inputs for the cycle are already driven; sample at the falling edge.
    task automatic step(input string tag, input logic [7:0] ctl, input logic hl,
                        input logic er, input state_t st);
        exp_t e;
        e = '{ctl: ctl, hl: hl, er: er, st: st, stall: exp_stall};
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({tag, "/ctl"},    {8'h00, ctl_obs},     {8'h00, e.ctl});
        chk({tag, "/halted"}, {15'h0, halted},      {15'h0, e.hl});
        chk({tag, "/err"},    {15'h0, err},         {15'h0, e.er});
        chk({tag, "/state"},  {14'h0, state},       {14'h0, e.st});
        chk({tag, "/stall"},  stall_cycles,         e.stall);
        if (rst) exp_stall = 16'h0000;
`ifdef PIPE_STALL_CNT_EN
        else if (!e.ctl[7] && e.st != HALT && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step("reset", C_RUN, 1'b0, 1'b0, RUN);
        rst = 1'b0;

        set_load_use(1'b1);
        step("lu_rt_stall", C_LU, 1'b0, 1'b0, RUN);
        step("lu_rt_hold", C_RUN, 1'b0, 1'b0, LU);
        clear_in();
        step("lu_rt_exit", C_RUN, 1'b0, 1'b0, RUN);

        set_load_use(1'b1);
        ID_rt_used = 1'b0;
        step("rt_unused", C_RUN, 1'b0, 1'b0, RUN);
        ID_rt_used = 1'b1;
        IE_mem_wr  = 1'b1;
        step("store_r3", C_RUN, 1'b0, 1'b0, RUN);

        clear_in();
        set_load_use(1'b0);
        step("lu_rs_stall", C_LU, 1'b0, 1'b0, RUN);
        clear_in();
        step("lu_rs_hold", C_RUN, 1'b0, 1'b0, LU);
        step("lu_rs_exit", C_RUN, 1'b0, 1'b0, RUN);

        IM_mem_en = 1'b1;
        step("miss_entry", C_MISS, 1'b0, 1'b0, RUN);
        for (int i = 0; i < 3; i++) step("memw_wait", C_MISS, 1'b0, 1'b0, MEMW);
        mem_done = 1'b1;
        step("memw_done", C_RUN, 1'b0, 1'b0, MEMW);
        clear_in();
        step("after_miss", C_RUN, 1'b0, 1'b0, RUN);

        IM_mem_en = 1'b1;
        step("to_entry", C_MISS, 1'b0, 1'b0, RUN);
        for (int i = 1; i <= 15; i++) step("to_wait", C_MISS, 1'b0, 1'b0, MEMW);
        step("to_err", C_MISS, 1'b0, 1'b1, MEMW);
        step("to_err_sticky", C_MISS, 1'b0, 1'b1, MEMW);
        clear_in();
        rst = 1'b1;
        step("to_rst", C_RUN, 1'b0, 1'b1, MEMW);
        rst = 1'b0;
        step("to_post_rst", C_RUN, 1'b0, 1'b0, RUN);

        set_load_use(1'b1);
        IE_branch_taken = 1'b1;
        step("br_and_lu", C_BR, 1'b0, 1'b0, RUN);
        clear_in();
        step("br_no_lu", C_RUN, 1'b0, 1'b0, RUN);

        IM_HALT = 1'b1;
        step("halt_entry", C_HENT, 1'b0, 1'b0, RUN);
        IM_HALT = 1'b0;
        IE_branch_taken = 1'b1;
        IM_mem_en = 1'b1;
        for (int i = 0; i < 10; i++) step("halted", C_HALT, 1'b1, 1'b0, HALT);
        clear_in();
        rst = 1'b1;
        step("halt_rst", C_RUN, 1'b0, 1'b0, HALT);
        rst = 1'b0;
        step("halt_post_rst", C_RUN, 1'b0, 1'b0, RUN);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
